dac_frame_pacer: RTL and testbench

- Downstream of the harmonic sample generator; replaces its direct timer/dac_send handshake to the DAC.
- Buffers computed 16-bit samples in a small FIFO and releases exactly one sample every SAMPLE_INTERVAL clocks.
- Serialises each released sample as a 24-bit MAX5134 write frame (command byte + sample) on SPI.
- On underrun, repeats the last sample and flags the error.

---
 rtl/dac_pkg.sv | 21 ++
 rtl/dac_frame_pacer_if.sv | 23 ++
 rtl/sample_fifo.sv | 65 ++++++
 rtl/dac_frame_pacer.sv | 150 +++++++++++++++
 tb/tb_dac_frame_pacer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// Shared constants and types for the DAC frame pacer: MAX5134 commands,
// frame geometry and the serializer state encoding.
package dac_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned FRAME_W  = 24;

  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

  localparam logic [7:0] CMD_WRITE_A = 8'b0011_0001;
  localparam logic [7:0] CMD_WRITE_B = 8'b0011_0010;
  localparam logic [7:0] CMD_UPDATE  = 8'b0000_0001;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } pacer_state_t;

endpackage

// File: rtl/dac_frame_pacer_if.sv
// Sample handshake between the harmonic generator (master) and the pacer (slave).
interface dac_frame_pacer_if;

  logic [dac_pkg::SAMPLE_W-1:0] sample_in;
  logic                         sample_valid;
  logic                         sample_ready;
  logic                         sample_tick;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready,
    input  sample_tick
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready,
    output sample_tick
  );

endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with registered ready and occupancy; head word is
// presented combinationally on pop_data.
module sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      level
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [AW:0]      level_next;

  // Ready is registered, so a full FIFO refuses a push even when a pop
  // frees a slot on the same edge.
  always_comb begin
    do_push    = push_valid && push_ready;
    do_pop     = pop && (level != '0);
    level_next = level;
    if (do_push && !do_pop) begin
      level_next = level + 1'b1;
    end else if (!do_push && do_pop) begin
      level_next = level - 1'b1;
    end
  end

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      push_ready <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level      <= level_next;
      push_ready <= (level_next != (AW + 1)'(DEPTH));
    end
  end

endmodule

// File: rtl/dac_frame_pacer.sv
// Releases one buffered sample every SAMPLE_INTERVAL clocks and serialises it
// as a 24-bit MAX5134 SPI write; repeats the last sample on underrun.
module dac_frame_pacer
  import dac_pkg::*;
#(
  parameter int unsigned SAMPLE_INTERVAL = 1500,
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned FIFO_AW         = 2,
  parameter logic [7:0]  COMMAND         = CMD_WRITE_A,
  parameter int unsigned CS_SETUP        = 2,
  parameter int unsigned CS_HOLD         = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  dac_frame_pacer_if.slave     sample_bus,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 underrun,
  output logic                 spi_cs_out,
  output logic                 spi_clock_out,
  output logic                 spi_data_out
);

  localparam int unsigned FRAME_LEN = CS_SETUP + 2 * FRAME_W * CLK_DIV + CS_HOLD;
  localparam int unsigned TIMER_W   = $clog2(SAMPLE_INTERVAL);
  localparam int unsigned CNT_MAX   = (CLK_DIV > CS_SETUP)
                                      ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                                      : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int unsigned CNT_W     = $clog2(CNT_MAX) + 1;

  if (FRAME_LEN + 1 >= SAMPLE_INTERVAL) begin : g_interval_check
    $error("dac_frame_pacer: SAMPLE_INTERVAL too short for one SPI frame");
  end

  pacer_state_t          state;
  logic [TIMER_W-1:0]    timer;
  logic                  tick;
  logic                  have_sample;
  logic [SAMPLE_W-1:0]   fifo_head;
  logic [SAMPLE_W-1:0]   last_sample;
  logic [SAMPLE_W-1:0]   frame_sample;
  logic [FRAME_W-1:0]    shift_reg;
  logic [CNT_W-1:0]      cnt;
  logic [4:0]            bit_cnt;
  logic                  tick_q;
  logic                  ready;

  assign tick         = (timer == TIMER_W'(SAMPLE_INTERVAL - 1));
  assign have_sample  = (fifo_level != '0);
  assign frame_sample = have_sample ? fifo_head : last_sample;

  assign sample_bus.sample_ready = ready;
  assign sample_bus.sample_tick  = tick_q;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_data  (sample_bus.sample_in),
    .push_valid (sample_bus.sample_valid),
    .push_ready (ready),
    .pop        (tick),
    .pop_data   (fifo_head),
    .level      (fifo_level)
  );

  always_ff @(posedge clock) begin
    if (reset || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      spi_cs_out    <= 1'b1;
      spi_clock_out <= 1'b1;
      spi_data_out  <= 1'b0;
      shift_reg     <= '0;
      last_sample   <= MIDSCALE;
      underrun      <= 1'b0;
      tick_q        <= 1'b0;
      cnt           <= '0;
      bit_cnt       <= '0;
    end else begin
      tick_q <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            if (have_sample) begin
              last_sample <= fifo_head;
              tick_q      <= 1'b1;
            end else begin
              underrun <= 1'b1;
            end
            shift_reg    <= {COMMAND, frame_sample};
            spi_data_out <= COMMAND[7];
            spi_cs_out   <= 1'b0;
            cnt          <= '0;
            state        <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == CNT_W'(CS_SETUP - 1)) begin
            cnt           <= '0;
            bit_cnt       <= '0;
            spi_clock_out <= 1'b0;
            state         <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          // MOSI advances only on the rising edge; the final high half-period
          // completes before HOLD so the frame spans 48 half-periods.
          if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt <= '0;
            if (!spi_clock_out) begin
              spi_clock_out <= 1'b1;
              spi_data_out  <= shift_reg[FRAME_W-2];
              shift_reg     <= {shift_reg[FRAME_W-2:0], 1'b0};
            end else if (bit_cnt == 5'(FRAME_W - 1)) begin
              state <= HOLD;
            end else begin
              spi_clock_out <= 1'b0;
              bit_cnt       <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == CNT_W'(CS_HOLD - 1)) begin
            cnt          <= '0;
            spi_cs_out   <= 1'b1;
            spi_data_out <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_frame_pacer.sv
// Randomised bench for dac_frame_pacer against a queue-based pacing model and
// an SPI frame decoder.
module tb_dac_frame_pacer;

  localparam int INTERVAL = 1500;
  localparam int FRAME_CLOCKS = 100;

  typedef struct {
    int          cyc;
    logic [23:0] data;
  } frame_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] fifo_level;
  logic       underrun;
  logic       spi_cs_out;
  logic       spi_clock_out;
  logic       spi_data_out;

  dac_frame_pacer_if bus ();

  dac_frame_pacer #(
    .SAMPLE_INTERVAL (1500),
    .CLK_DIV         (2),
    .FIFO_AW         (2),
    .COMMAND         (8'b0011_0001),
    .CS_SETUP        (2),
    .CS_HOLD         (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .sample_bus    (bus),
    .fifo_level    (fifo_level),
    .underrun      (underrun),
    .spi_cs_out    (spi_cs_out),
    .spi_clock_out (spi_clock_out),
    .spi_data_out  (spi_data_out)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [15:0] m_q[$];
  logic [15:0] m_last = 16'h8000;
  bit          m_under = 1'b0;
  bit          m_tick = 1'b0;
  bit          m_ready = 1'b0;
  int          cyc = 0;
  frame_t      exp_frames[$];
  logic [15:0] script[$];

  task automatic drive(input int mode);
    bus.sample_in = 16'($urandom);
    case (mode)
      1: begin
        bus.sample_valid = (script.size() > 0);
        if (script.size() > 0) bus.sample_in = script[0];
      end
      2: bus.sample_valid = (m_q.size() < 2) || (((cyc + 1) % INTERVAL) == 0);
      3: bus.sample_valid = ($urandom_range(0, 3) == 0);
      default: bus.sample_valid = 1'b0;
    endcase
  endtask

  task automatic step();
    bit          push_ok;
    logic [15:0] din;
    frame_t      f;
    push_ok = bus.sample_valid && m_ready;
    din     = bus.sample_in;
    @(posedge clock);
    if (reset) begin
      m_q.delete();
      exp_frames.delete();
      m_last  = 16'h8000;
      m_under = 1'b0;
      m_tick  = 1'b0;
      m_ready = 1'b0;
      cyc     = 0;
    end else begin
      cyc++;
      m_tick = 1'b0;
      if (cyc % INTERVAL == 0) begin
        if (m_q.size() > 0) begin
          m_last = m_q.pop_front();
          m_tick = 1'b1;
        end else begin
          m_under = 1'b1;
        end
        f.cyc  = cyc;
        f.data = {8'h31, m_last};
        exp_frames.push_back(f);
      end
      if (push_ok) begin
        m_q.push_back(din);
        if (script.size() > 0) void'(script.pop_front());
      end
      m_ready = (m_q.size() != 4);
    end
    #1;
    check_eq("sample_tick", 32'(bus.sample_tick), 32'(m_tick));
    check_eq("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check_eq("underrun", 32'(underrun), 32'(m_under));
    check_eq("sample_ready", 32'(bus.sample_ready), 32'(m_ready));
    if (reset) begin
      check_eq("rst_cs", 32'(spi_cs_out), 32'd1);
      check_eq("rst_sclk", 32'(spi_clock_out), 32'd1);
      check_eq("rst_mosi", 32'(spi_data_out), 32'd0);
    end
  endtask

  task automatic run(input int n, input int mode);
    repeat (n) begin
      drive(mode);
      step();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    script.delete();
    repeat (n) begin
      drive(0);
      step();
    end
    reset = 1'b0;
  endtask

  // SPI decoder: collects MOSI on SCLK falling edges while CS is low
  bit          mon_in_frame = 1'b0;
  logic        mon_prev_sclk = 1'b1;
  int          mon_low_cnt = 0;
  int          mon_bits = 0;
  int          mon_start = 0;
  logic [23:0] mon_data = '0;
  frame_t      mon_exp;

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_in_frame = 1'b0;
      end else if (spi_cs_out === 1'b0) begin
        if (!mon_in_frame) begin
          mon_in_frame  = 1'b1;
          mon_start     = cyc;
          mon_low_cnt   = 0;
          mon_bits      = 0;
          mon_data      = '0;
          mon_prev_sclk = 1'b1;
        end
        mon_low_cnt++;
        if (mon_prev_sclk === 1'b1 && spi_clock_out === 1'b0) begin
          mon_data = {mon_data[22:0], spi_data_out};
          mon_bits++;
        end
        mon_prev_sclk = spi_clock_out;
      end else if (mon_in_frame) begin
        mon_in_frame = 1'b0;
        check_eq("frame_expected", 32'(exp_frames.size() > 0), 32'd1);
        if (exp_frames.size() > 0) begin
          mon_exp = exp_frames.pop_front();
          check_eq("frame_data", 32'(mon_data), 32'(mon_exp.data));
          check_eq("frame_start", 32'(mon_start), 32'(mon_exp.cyc));
          check_eq("frame_cs_low", 32'(mon_low_cnt), 32'(FRAME_CLOCKS));
          check_eq("frame_bits", 32'(mon_bits), 32'd24);
        end
      end
    end
  end

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;

    // Single sample, then idle
    do_reset(3);
    script.push_back(16'h1234);
    run(1700, 1);
    check_eq("drained_single", 32'(exp_frames.size()), 32'd0);

    // Fill to full, fifth push held off until a slot frees
    do_reset(3);
    script.push_back(16'hAAAA);
    script.push_back(16'h5555);
    script.push_back(16'hFFFF);
    script.push_back(16'h0001);
    script.push_back(16'($urandom));
    run(7700, 1);
    check_eq("drained_full", 32'(exp_frames.size()), 32'd0);

    // Underrun first, then a late sample
    do_reset(3);
    run(1600, 0);
    script.push_back(16'h4000);
    run(1600, 1);
    check_eq("drained_underrun", 32'(exp_frames.size()), 32'd0);

    // One sample repeated on later ticks
    do_reset(3);
    script.push_back(16'h7777);
    run(4700, 1);
    check_eq("drained_repeat", 32'(exp_frames.size()), 32'd0);

    // Reset in the middle of a frame (around bit 10)
    do_reset(3);
    script.push_back(16'($urandom));
    script.push_back(16'($urandom));
    run(1543, 1);
    check_eq("cs_midframe", 32'(spi_cs_out), 32'd0);
    do_reset(1);
    run(1700, 0);
    check_eq("drained_midreset", 32'(exp_frames.size()), 32'd0);

    // Level held at 2 with push and pop on the same tick edge
    do_reset(3);
    run(12200, 2);
    check_eq("drained_level2", 32'(exp_frames.size()), 32'd0);

    // Sparse random pushes
    do_reset(3);
    run(9200, 3);
    check_eq("drained_random", 32'(exp_frames.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
